// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin 4:1 mux scheduler with bounded hold per grant
//
// Purpose: arbitrates four level-sensitive requesters round-robin, holds the grant for
// up to HOLD_MAX capture cycles, and registers the owner's data slice onto y.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req[3:0] in   request per requester (level)
//   din      in   4*W data, requester i on [i*W +: W]
//   gnt[3:0] out  registered one-hot grant, zero when idle
//   s1, s0   out  registered mux select, owner index = {s1,s0}
//   y        out  registered selected data
//   y_valid  out  y was captured at the last edge
//   busy     out  high while a grant is active
module mux_rr_scheduler #(
  parameter int W        = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  output logic [3:0]     gnt,
  output logic           s1,
  output logic           s0,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic           busy
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_ptr, w_ptr_nxt;
  logic [1:0]   r_owner, w_owner_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [3:0]   r_gnt, w_gnt_nxt;
  logic [1:0]   r_sel, w_sel_nxt;
  logic [W-1:0] r_y, w_y_nxt;
  logic         r_y_valid, w_y_valid_nxt;

  logic         w_capture;
  logic         w_release;
  logic [3:0]   w_cnt_inc;
  logic [1:0]   w_arb_start;
  logic [2:0]   w_pick;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  // Scanning downward lets the lowest offset overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_capture = (r_state == S_GRANT) && req[r_owner];
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_release = (r_state == S_GRANT) &&
                     (!req[r_owner] || (w_cnt_inc == 4'(HOLD_MAX)));

  // On release the search starts just past the owner, so a still-requesting owner
  // sits at lowest priority; a dropped owner has req bit 0 and cannot win.
  assign w_arb_start = (r_state == S_IDLE) ? r_ptr : (r_owner + 2'd1);
  assign w_pick      = rr_pick(req, w_arb_start);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_y_nxt       = r_y;
    w_y_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick[2]) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick[1:0];
          w_sel_nxt   = w_pick[1:0];
          w_gnt_nxt   = 4'b0001 << w_pick[1:0];
          w_cnt_nxt   = 4'd0;
        end else begin
          w_gnt_nxt   = 4'b0000;
        end
      end
      S_GRANT: begin
        if (w_capture) begin
          w_y_nxt       = din[r_owner*W +: W];
          w_y_valid_nxt = 1'b1;
          w_cnt_nxt     = w_cnt_inc;
        end
        if (w_release) begin
          w_ptr_nxt = r_owner + 2'd1;
          w_cnt_nxt = 4'd0;
          if (w_pick[2]) begin
            w_owner_nxt = w_pick[1:0];
            w_sel_nxt   = w_pick[1:0];
            w_gnt_nxt   = 4'b0001 << w_pick[1:0];
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_cnt     <= 4'd0;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign s1      = r_sel[1];
  assign s0      = r_sel[0];
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign busy    = (r_state == S_GRANT);

endmodule
